// File: rtl/mlp_pkg.sv
// Shared types and widths for the MLP register-file write path.
package mlp_pkg;

  localparam int RF_ADDR_W = 7;
  localparam int RF_DATA_W = 8;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_RUN,
    RF_DONE
  } rf_seq_state_t;

endpackage

// File: rtl/rf_write_sequencer_if.sv
// Control, source handshake and RF write port of the write sequencer.
interface rf_write_sequencer_if
  import mlp_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_period;
  logic [ADDR_W-1:0] cfg_last;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done;
  logic              overrun;

  modport slave (
    input  start, abort, cfg_period, cfg_last, src_valid, src_data,
    output src_ready, rf_we, rf_waddr, rf_wdata, busy, done, overrun
  );

  modport master (
    output start, abort, cfg_period, cfg_last, src_valid, src_data,
    input  src_ready, rf_we, rf_waddr, rf_wdata, busy, done, overrun
  );

endinterface

// File: rtl/rf_tick_gen.sv
// Strobe prescaler: one tick every period+1 enabled cycles, in place of a derived clock.
module rf_tick_gen
  import mlp_pkg::*;
#(
  parameter int W = RF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] div_cnt;

  assign tick = en && (div_cnt == period);

  // Held at zero while disabled so the first tick lands period+1 cycles after enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Sequences one layer's activations into RF addresses 0..cfg_last, one word per tick.
module rf_write_sequencer
  import mlp_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_write_sequencer_if.slave  bus
);

  rf_seq_state_t     state;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] period_q;
  logic [ADDR_W-1:0] last_q;
  logic              pending;
  logic              overrun_q;
  logic              run_en;
  logic              tick;
  logic              win;
  logic              transfer;
  logic [DATA_W-1:0] wdata;

  assign run_en = (state == RF_RUN);

  rf_tick_gen #(.W(ADDR_W)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (run_en),
    .period (period_q),
    .tick   (tick)
  );

  // Abort closes the window outright, so it beats a same-cycle transfer.
  assign win      = run_en && (tick || pending) && !bus.abort;
  assign transfer = win && bus.src_valid;
  assign wdata    = bus.src_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RF_IDLE;
      waddr_q   <= '0;
      period_q  <= '0;
      last_q    <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (bus.start) begin
            state     <= RF_RUN;
            period_q  <= bus.cfg_period;
            last_q    <= bus.cfg_last;
            waddr_q   <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
          end
        end
        RF_RUN: begin
          if (bus.abort) begin
            state <= RF_IDLE;
          end else begin
            // A tick landing on an unserved pending word is dropped, not queued.
            if (tick && pending && !transfer) begin
              overrun_q <= 1'b1;
            end
            if (transfer) begin
              pending <= 1'b0;
              if (waddr_q == last_q) begin
                state <= RF_DONE;
              end else begin
                waddr_q <= waddr_q + 1'b1;
              end
            end else if (tick) begin
              pending <= 1'b1;
            end
          end
        end
        RF_DONE: state <= RF_IDLE;
        default: state <= RF_IDLE;
      endcase
    end
  end

  assign bus.src_ready = win;
  assign bus.rf_we     = transfer;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata;
  assign bus.busy      = run_en;
  assign bus.done      = (state == RF_DONE);
  assign bus.overrun   = overrun_q;

endmodule
